// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - raw key inputs and debounced level/pulse outputs between pads and debouncer
interface key_debounce_if #(
  parameter int KEY_W = 4
);
  logic [KEY_W-1:0] key_in;
  logic [KEY_W-1:0] key_state;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;
  logic [KEY_W-1:0] key_long;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchronizer, debounce FSM and press/release/long pulses
// Optional long-press detection is compiled in with KEY_LONG_PRESS_EN.
module key_debounce #(
  parameter int KEY_W    = 4,
  parameter int DEB_CYC  = 1_000_000,
  parameter int LONG_CYC = 50_000_000
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  key_debounce_if.slave  kif
);
  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  typedef enum logic {
    IDLE_UP = 1'b0,
    HELD    = 1'b1
  } state_t;

  logic [KEY_W-1:0] state_vec;
  logic [KEY_W-1:0] press_vec;
  logic [KEY_W-1:0] release_vec;
  logic [KEY_W-1:0] long_vec;

  for (genvar ch = 0; ch < KEY_W; ch++) begin : g_ch
    logic             sync_a;
    logic             sync_b;
    logic             s;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;

    // Sync flops hold the raw active-low level, so reset to 1 means released.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync_a    <= 1'b1;
        sync_b    <= 1'b1;
        state_q   <= IDLE_UP;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_a    <= kif.key_in[ch];
        sync_b    <= sync_a;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    assign s = ~sync_b;

    always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
        IDLE_UP: begin
          if (s) begin
            if (cnt_q == DEB_LAST) begin
              state_d = HELD;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HELD: begin
          if (!s) begin
            if (cnt_q == DEB_LAST) begin
              state_d   = IDLE_UP;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE_UP;
      endcase
    end

    assign state_vec[ch]   = (state_q == HELD);
    assign press_vec[ch]   = press_q;
    assign release_vec[ch] = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYC);

    logic [LONG_W-1:0] long_cnt_q;
    logic [LONG_W-1:0] long_cnt_d;
    logic              long_q;
    logic              long_d;

    // Counts only while held on both sides of the edge: the press edge and any release clear it.
    always_comb begin
      long_cnt_d = '0;
      long_d     = 1'b0;
      if (state_q == HELD && state_d == HELD) begin
        if (long_cnt_q != LONG_MAX) begin
          long_cnt_d = long_cnt_q + 1'b1;
          long_d     = (long_cnt_q == LONG_MAX - 1'b1);
        end else begin
          long_cnt_d = long_cnt_q;
        end
      end
    end

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        long_cnt_q <= '0;
        long_q     <= 1'b0;
      end else begin
        long_cnt_q <= long_cnt_d;
        long_q     <= long_d;
      end
    end

    assign long_vec[ch] = long_q;
`else
    assign long_vec[ch] = 1'b0;
`endif
  end

  assign kif.key_state   = state_vec;
  assign kif.key_press   = press_vec;
  assign kif.key_release = release_vec;
  assign kif.key_long    = long_vec;
endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed bench for key_debounce with DEB_CYC=8, LONG_CYC=32
module tb_key_debounce;
  logic sys_clk;
  logic sys_rst;
  int   total;
  int   passed;
  int   failed;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [3:0] LONG1 = 4'b0010;
`else
  localparam logic [3:0] LONG1 = 4'b0000;
`endif

  key_debounce_if #(.KEY_W(4)) kif ();

  key_debounce #(
    .KEY_W   (4),
    .DEB_CYC (8),
    .LONG_CYC(32)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .kif    (kif)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  // Advance n cycles; after each rising edge compare all four outputs at the falling edge.
  task automatic run_chk(input int n, input string tag, input logic [3:0] st,
                         input logic [3:0] pr, input logic [3:0] rl, input logic [3:0] lg);
    logic [15:0] obs;
    logic [15:0] exp;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      obs = {kif.key_state, kif.key_press, kif.key_release, kif.key_long};
      exp = {st, pr, rl, lg};
      total++;
      assert (obs === exp) passed++;
      else begin
        failed++;
        $error("FAIL %s[%0d]: state/press/release/long observed %b expected %b", tag, i, obs, exp);
      end
    end
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    failed     = 0;
    sys_rst    = 1'b1;
    kif.key_in = 4'b1111;

    // 1. reset
    run_chk(3, "reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    sys_rst = 1'b0;
    run_chk(4, "idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 2. clean press and release of key 0
    kif.key_in[0] = 1'b0;
    run_chk(9, "p0_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "p0_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    run_chk(5, "p0_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[0] = 1'b1;
    run_chk(9, "r0_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "r0_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    run_chk(3, "r0_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 3. key 1 bounces every 3 cycles, final toggle leaves it low
    for (int t = 0; t < 10; t++) begin
      kif.key_in[1] = (t % 2 == 0) ? 1'b0 : 1'b1;
      run_chk(3, "bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end
    kif.key_in[1] = 1'b0;
    run_chk(9, "b1_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "b1_press", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    run_chk(3, "b1_hold", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[1] = 1'b1;
    run_chk(9, "b1_rwait", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "b1_release", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    run_chk(2, "b1_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 4. keys 2 and 3 together
    kif.key_in[3:2] = 2'b00;
    run_chk(9, "p23_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "p23_press", 4'b1100, 4'b1100, 4'b0000, 4'b0000);
    run_chk(10, "p23_hold", 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[3:2] = 2'b11;
    run_chk(9, "r23_wait", 4'b1100, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "r23_release", 4'b0000, 4'b0000, 4'b1100, 4'b0000);
    run_chk(2, "r23_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 5. reset while key 0 debounce count is at 5, key held through reset
    kif.key_in[0] = 1'b0;
    run_chk(7, "mid_count", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    sys_rst = 1'b1;
    run_chk(1, "mid_rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    sys_rst = 1'b0;
    run_chk(9, "post_rst_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "post_rst_press", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    run_chk(2, "post_rst_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[0] = 1'b1;
    run_chk(9, "post_rst_rwait", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "post_rst_rel", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    run_chk(2, "post_rst_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 6. long hold of key 1 (key_long only when the feature is built in)
    kif.key_in[1] = 1'b0;
    run_chk(9, "l1_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "l1_press", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    run_chk(31, "l1_count", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "l1_long", 4'b0010, 4'b0000, 4'b0000, LONG1);
    run_chk(68, "l1_saturate", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[1] = 1'b1;
    run_chk(9, "l1_rwait", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "l1_release", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    run_chk(2, "l1_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // short hold released after 20 cycles never reaches the long threshold
    kif.key_in[1] = 1'b0;
    run_chk(9, "s1_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "s1_press", 4'b0010, 4'b0010, 4'b0000, 4'b0000);
    run_chk(19, "s1_hold", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    kif.key_in[1] = 1'b1;
    run_chk(9, "s1_rwait", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    run_chk(1, "s1_release", 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    run_chk(5, "s1_quiet", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
